fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Producer side of the IF/ID interface: holds the fetch PC and requests instruction words from instruction memory.
- Buffers returned words in a small FIFO.
- Presents the head entry as instruction/PCF/PCPlus4F to the IF/ID pipeline register.
- Honours StallF from the hazard unit and redirects on taken branches/jumps (PCSrcE), discarding all stale fetches.

Parameters:
RESET_PC, 32'h00000000, first fetch address after reset
BUF_DEPTH, 2, fetch buffer entries (power of two, >=2)

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous active-high reset
StallF  input  1  decode not accepting; hold head entry
PCSrcE  input  1  redirect request from execute
PCTargetE  input  32  redirect target address
imem_req  output  1  instruction memory read request (one-cycle pulse per fetch)
imem_addr  output  32  read address, valid when imem_req=1
imem_rvalid  input  1  read data valid
imem_rdata  input  32  read data
instruction  output  32  head instruction, 0 when FetchValid=0
PCF  output  32  head PC, 0 when FetchValid=0
PCPlus4F  output  32  PCF+4, 0 when FetchValid=0
FetchValid  output  1  head entry present

Behaviour:
- Clocking and reset: one clock (clk); rst is synchronous, active-high.
- Reset state:
  - fetch_pc=RESET_PC, buffer count=0, outstanding=0, kill=0.
  - While rst=1: imem_req=0, imem_addr=0, FetchValid=0, instruction/PCF/PCPlus4F=0.
- Issue (combinational):
  - imem_req=1 iff !rst && !PCSrcE && outstanding==0 && count<BUF_DEPTH.
  - imem_addr=fetch_pc.
  - On issue: outstanding<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32, wraps 32'hFFFFFFFC->0).
- Memory contract:
  - In-order responses; latency >=1 cycle.
  - At most one request outstanding, so throughput peaks at one word per 2 cycles.
  - imem_rvalid with outstanding==0 is ignored.
- Response:
  - On imem_rvalid && outstanding: outstanding<=0.
  - If kill==0 && !PCSrcE: push {imem_rdata, req_pc} at tail.
  - If kill==1: drop the word and clear kill.
- Head outputs:
  - FetchValid=(count!=0).
  - instruction/PCF from the head entry; PCPlus4F=PCF+4.
  - All three forced to 0 when the buffer is empty; this matches IF/ID flush value.
  - Pushed data is visible at the head the cycle after imem_rvalid (no bypass).
- Pop: FetchValid && !StallF && !PCSrcE at the clock edge removes the head.
- Simultaneous push+pop: count unchanged, pointers both advance.
  - Issue rule (count<BUF_DEPTH, one outstanding) guarantees a push never overflows.
- Redirect (PCSrcE=1), highest priority, overrides StallF and same-cycle rvalid:
  - Buffer cleared (count<=0, pointers<=0).
  - fetch_pc<={PCTargetE[31:2],2'b00}; low bits are forced to 0.
  - If a request is outstanding and not returning this cycle: kill<=1.
  - A response arriving in the same cycle is dropped.
  - No request is issued in the redirect cycle; the first request to the target is issued the next cycle.
- Reset mid-operation:
  - Outstanding request, kill and buffer are all discarded.
  - A late imem_rvalid after reset is ignored (outstanding==0).
- StallF with empty buffer: no effect; fetching continues until the buffer is full.

Test Plan:
- Reset release, RESET_PC=0, memory latency 1 returning 32'h00500093 for addr 0:
  - imem_req=1, addr=0 in cycle 0.
  - rvalid in cycle 1.
  - Cycle 2: FetchValid=1, instruction=32'h00500093, PCF=0, PCPlus4F=4.
- StallF held high for 6 cycles:
  - Buffer fills to 2 (PCs 0,4), then imem_req stays 0.
  - Head holds PCF=0.
  - On release, PCs 0,4,8 are presented in order with no loss or duplication.
- PCSrcE=1, PCTargetE=32'h100 while request to addr 8 is outstanding:
  - Buffer empties; FetchValid=0 next cycle.
  - The word for addr 8 is dropped.
  - Next imem_addr=32'h100; PCF=32'h100 appears afterwards.
- PCSrcE=1 in the same cycle as imem_rvalid:
  - Response dropped, kill not set.
  - Request to target issued the following cycle.
- PCTargetE=32'h00000207: next imem_addr=32'h00000204.
- Assert rst with a request outstanding and 1 entry buffered, then send stray imem_rvalid:
  - All outputs return to 0; the stray response is ignored.
  - First post-reset request goes to RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Producer side of the IF/ID interface. Holds the fetch PC and issues
//   single-word reads to instruction memory with at most one read in flight.
//   Returned words go into a small FIFO. The head entry is presented as
//   instruction / PCF / PCPlus4F to the IF/ID register. A redirect from
//   execute (PCSrcE) flushes the FIFO and discards any stale fetch.
//
// Ports
//   clk          in   clock, all state updates on posedge
//   rst          in   synchronous active-high reset
//   StallF       in   decode not accepting; hold the head entry
//   PCSrcE       in   redirect request from execute
//   PCTargetE    in   redirect target (low two bits ignored)
//   imem_req     out  one-cycle read request pulse
//   imem_addr    out  read address (0 while in reset)
//   imem_rvalid  in   read data valid
//   imem_rdata   in   read data
//   instruction  out  head instruction, 0 when FetchValid=0
//   PCF          out  head PC, 0 when FetchValid=0
//   PCPlus4F     out  PCF+4, 0 when FetchValid=0
//   FetchValid   out  head entry present
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        FetchValid
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_req_pc;
  logic             r_outstanding;
  logic             r_kill;
  logic [CNT_W-1:0] r_count;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [31:0]      r_buf_instr [BUF_DEPTH];
  logic [31:0]      r_buf_pc    [BUF_DEPTH];

  logic        w_issue;
  logic        w_resp;
  logic        w_push;
  logic        w_pop;
  logic        w_has_head;
  logic [31:0] w_head_pc;

  // Issue only when nothing is in flight and a FIFO slot is guaranteed free
  // for the returning word, so a push can never overflow.
  assign w_issue = !rst && !PCSrcE && !r_outstanding && (r_count < DEPTH_C);
  // Responses with nothing in flight (e.g. arriving after reset) are ignored.
  assign w_resp  = imem_rvalid && r_outstanding;
  assign w_push  = w_resp && !r_kill && !PCSrcE;
  assign w_pop   = (r_count != '0) && !StallF && !PCSrcE;

  assign imem_req  = w_issue;
  assign imem_addr = rst ? 32'h0 : r_fetch_pc;

  // Head outputs read as zero when empty so IF/ID sees the flush value.
  assign w_has_head  = !rst && (r_count != '0);
  assign w_head_pc   = r_buf_pc[r_rd_ptr];
  assign FetchValid  = w_has_head;
  assign instruction = w_has_head ? r_buf_instr[r_rd_ptr] : 32'h0;
  assign PCF         = w_has_head ? w_head_pc : 32'h0;
  assign PCPlus4F    = w_has_head ? (w_head_pc + 32'd4) : 32'h0;

  // FIFO storage; one write-enabled register pair per slot.
  for (genvar gi = 0; gi < BUF_DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (!rst && w_push && (r_wr_ptr == PTR_W'(gi))) begin
        r_buf_instr[gi] <= imem_rdata;
        r_buf_pc[gi]    <= r_req_pc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_req_pc      <= 32'h0;
      r_outstanding <= 1'b0;
      r_kill        <= 1'b0;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      // Issue and response are mutually exclusive (issue needs nothing in flight).
      if (w_issue) begin
        r_outstanding <= 1'b1;
        r_req_pc      <= r_fetch_pc;
      end else if (w_resp) begin
        r_outstanding <= 1'b0;
      end

      // Any returning word consumes the kill; a redirect with a read still in
      // flight arms it so that the stale word is dropped when it lands.
      if (w_resp) begin
        r_kill <= 1'b0;
      end else if (PCSrcE && r_outstanding) begin
        r_kill <= 1'b1;
      end

      if (PCSrcE) begin
        r_fetch_pc <= PCTargetE & 32'hFFFF_FFFC;
        r_count    <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_issue) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. A memory model answers each request after
//   1+mem_extra cycles. Expected head entries are queued by the stimulus; a
//   monitor compares every entry the DUT hands to decode against the queue.
//   Directed spot checks cover issue addresses, stalls, redirects and reset.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        StallF;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;
  logic        FetchValid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_ins_q[$];

  int  mem_extra = 0;
  logic stray = 1'b0;

  fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .StallF(StallF), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instruction(instruction), .PCF(PCF),
    .PCPlus4F(PCPlus4F), .FetchValid(FetchValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return a ^ 32'h1357_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", name, got);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_pc_q.push_back(pc);
    exp_ins_q.push_back(memf(pc));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Memory model: in-order, one request at a time, latency 1+mem_extra.
  // Forgets its pending read when it sees reset; 'stray' injects a bogus
  // response in the next cycle.
  initial begin : mem_model
    logic        s_req, s_rst, pend;
    logic [31:0] s_addr, pend_addr;
    int          pend_wait;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    pend = 1'b0; pend_addr = 32'h0; pend_wait = 0;
    forever begin
      @(posedge clk);
      s_req = imem_req; s_addr = imem_addr; s_rst = rst;
      #1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      if (s_rst) begin
        pend = 1'b0;
      end else if (s_req) begin
        pend = 1'b1; pend_addr = s_addr; pend_wait = mem_extra;
      end
      if (stray) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        stray = 1'b0;
      end else if (pend) begin
        if (pend_wait == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = memf(pend_addr);
          pend = 1'b0;
        end else begin
          pend_wait--;
        end
      end
    end
  end

  // Monitor: every accepted head entry must match the scoreboard front;
  // an empty buffer must present all-zero head fields.
  always @(negedge clk) begin
    if (!rst) begin
      if (!FetchValid) begin
        n_tests++;
        if ((instruction | PCF | PCPlus4F) != 32'h0) begin
          n_fail++;
          $display("FAIL empty_zero: got ins=%h pc=%h pc4=%h expected all 0",
                   instruction, PCF, PCPlus4F);
        end
      end else if (!StallF && !PCSrcE) begin
        n_tests++;
        if (exp_pc_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got pc=%h expected no entry", PCF);
        end else begin
          logic [31:0] e_pc, e_ins;
          e_pc  = exp_pc_q.pop_front();
          e_ins = exp_ins_q.pop_front();
          if (instruction !== e_ins || PCF !== e_pc || PCPlus4F !== e_pc + 32'd4) begin
            n_fail++;
            $display("FAIL pop: got ins=%h pc=%h pc4=%h expected ins=%h pc=%h pc4=%h",
                     instruction, PCF, PCPlus4F, e_ins, e_pc, e_pc + 32'd4);
          end else begin
            $display("[TB] pop  pc=%h ins=%h", PCF, instruction);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1; StallF = 1'b1; PCSrcE = 1'b0; PCTargetE = 32'h0;

    // Reset state
    next_cycle();
    @(negedge clk);
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, FetchValid}, 32'h0);
    chk("rst_ins", instruction, 32'h0);
    chk("rst_pcf", PCF, 32'h0);
    chk("rst_pc4", PCPlus4F, 32'h0);

    // c0: first request to RESET_PC
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    chk("c0_req", {31'h0, imem_req}, 32'h1);
    chk("c0_addr", imem_addr, 32'h0);
    // c1: response in flight, nothing buffered yet (no bypass)
    next_cycle();
    @(negedge clk);
    chk("c1_req", {31'h0, imem_req}, 32'h0);
    chk("c1_valid", {31'h0, FetchValid}, 32'h0);
    // c2: head presents addr 0, next fetch to 4
    next_cycle();
    @(negedge clk);
    chk("c2_valid", {31'h0, FetchValid}, 32'h1);
    chk("c2_ins", instruction, 32'h0050_0093);
    chk("c2_pcf", PCF, 32'h0);
    chk("c2_pc4", PCPlus4F, 32'h4);
    chk("c2_addr", imem_addr, 32'h4);
    chk("c2_req", {31'h0, imem_req}, 32'h1);
    // c3..c5: stalled, buffer full, head holds PC 0
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("c4_req_full", {31'h0, imem_req}, 32'h0);
    chk("c4_pcf", PCF, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("c5_req_full", {31'h0, imem_req}, 32'h0);
    chk("c5_pcf", PCF, 32'h0);
    // c6: release one pop (PC 0)
    next_cycle(); push_exp(32'h0); StallF = 1'b0;
    @(negedge clk);
    chk("c6_req", {31'h0, imem_req}, 32'h0);
    // c7: stall again; addr 8 issued with slow response
    next_cycle(); StallF = 1'b1; mem_extra = 3;
    @(negedge clk);
    chk("c7_req", {31'h0, imem_req}, 32'h1);
    chk("c7_addr", imem_addr, 32'h8);
    chk("c7_pcf", PCF, 32'h4);
    // c8: redirect to 0x100 while addr 8 outstanding
    next_cycle(); PCSrcE = 1'b1; PCTargetE = 32'h100;
    @(negedge clk);
    chk("c8_req_redirect", {31'h0, imem_req}, 32'h0);
    next_cycle(); PCSrcE = 1'b0; mem_extra = 0;
    @(negedge clk);
    chk("c9_valid_flushed", {31'h0, FetchValid}, 32'h0);
    chk("c9_req_wait", {31'h0, imem_req}, 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("c11_req_wait", {31'h0, imem_req}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("c12_req", {31'h0, imem_req}, 32'h1);
    chk("c12_addr", imem_addr, 32'h100);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("c14_valid", {31'h0, FetchValid}, 32'h1);
    chk("c14_pcf", PCF, 32'h100);
    push_exp(32'h100); push_exp(32'h104);
    // c16/c17: drain both entries
    next_cycle();
    next_cycle(); StallF = 1'b0;
    @(negedge clk);
    chk("c16_req_full", {31'h0, imem_req}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("c17_addr", imem_addr, 32'h108);
    // c18: redirect coinciding with response for 0x108; unaligned target
    next_cycle(); StallF = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h0000_0207;
    @(negedge clk);
    chk("c18_req_redirect", {31'h0, imem_req}, 32'h0);
    next_cycle(); PCSrcE = 1'b0;
    @(negedge clk);
    chk("c19_req", {31'h0, imem_req}, 32'h1);
    chk("c19_addr_aligned", imem_addr, 32'h204);
    chk("c19_valid", {31'h0, FetchValid}, 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("c21_valid", {31'h0, FetchValid}, 32'h1);
    chk("c21_pcf", PCF, 32'h204);
    push_exp(32'h204);
    // c23: pop 0x204; c24: one entry left plus a slow read in flight
    next_cycle();
    next_cycle(); StallF = 1'b0;
    next_cycle(); StallF = 1'b1; mem_extra = 2;
    @(negedge clk);
    chk("c24_addr", imem_addr, 32'h20C);
    chk("c24_pcf", PCF, 32'h208);
    // c25: reset mid-operation
    next_cycle(); rst = 1'b1; mem_extra = 0;
    @(negedge clk);
    chk("c25_req", {31'h0, imem_req}, 32'h0);
    chk("c25_addr", imem_addr, 32'h0);
    chk("c25_valid", {31'h0, FetchValid}, 32'h0);
    chk("c25_ins", instruction, 32'h0);
    chk("c25_pcf", PCF, 32'h0);
    chk("c25_pc4", PCPlus4F, 32'h0);
    stray = 1'b1;
    // c26: stray response arrives; first request to RESET_PC
    next_cycle(); rst = 1'b0;
    @(negedge clk);
    chk("c26_req", {31'h0, imem_req}, 32'h1);
    chk("c26_addr", imem_addr, 32'h0);
    chk("c26_valid", {31'h0, FetchValid}, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("c27_stray_ignored", {31'h0, FetchValid}, 32'h0);
    next_cycle(); push_exp(32'h0); StallF = 1'b0;
    @(negedge clk);
    chk("c28_ins", instruction, 32'h0050_0093);
    chk("c28_pcf", PCF, 32'h0);
    next_cycle(); StallF = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("scoreboard_drained", exp_pc_q.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
